// File: rtl/prio_scan_ctrl_if.sv
// Handshake and control bundle between the candidate-mask producer, the scan
// controller and the index consumer.
interface prio_scan_ctrl_if #(
    parameter int unsigned WIDTH_LOG = 4
);
    localparam int unsigned WIDTH = 1 << WIDTH_LOG;

    logic                 go;
    logic                 abort;
    logic [WIDTH-1:0]     mask_in;
    logic                 busy;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           out_idx;
    logic                 out_last;
    logic                 done;
    logic [WIDTH_LOG:0]   count;

    // Master drives requests and consumes indices; slave is the scan controller.
    modport master (
        output go,
        output abort,
        output mask_in,
        output out_ready,
        input  busy,
        input  out_valid,
        input  out_idx,
        input  out_last,
        input  done,
        input  count
    );

    modport slave (
        input  go,
        input  abort,
        input  mask_in,
        input  out_ready,
        output busy,
        output out_valid,
        output out_idx,
        output out_last,
        output done,
        output count
    );
endinterface

// File: rtl/prio_scan_ctrl.sv
// Walks a captured candidate mask from its highest set bit downward, emitting one
// index per valid/ready handshake through a single shared priority encoder.
module prio_scan_ctrl #(
    parameter int unsigned WIDTH_LOG = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    prio_scan_ctrl_if.slave bus
);
    localparam int unsigned WIDTH = 1 << WIDTH_LOG;
    localparam int unsigned CW    = WIDTH_LOG + 1;

    typedef enum logic [1:0] {
        StIdle,
        StEmit,
        StFin
    } state_e;

    state_e           r_state,     w_state_next;
    logic [WIDTH-1:0] r_pending,   w_pending_d;
    logic [7:0]       r_out_idx,   w_out_idx_d;
    logic             r_out_valid, w_out_valid_d;
    logic             r_out_last,  w_out_last_d;
    logic             r_done,      w_done_d;
    logic             r_busy,      w_busy_d;
    logic [CW-1:0]    r_count,     w_count_d;

    logic [WIDTH-1:0] w_clr_mask;
    logic [WIDTH-1:0] w_pending_next;
    logic [WIDTH-1:0] w_enc_in;
    logic [7:0]       w_enc_idx;
    logic             w_enc_nonzero;
    logic             w_enc_single;

    always_comb begin
        w_clr_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_clr_mask[i] = (r_out_idx == 8'(i));
        end
    end

    assign w_pending_next = r_pending & ~w_clr_mask;

    // One encoder serves both the capture and every scan step; mask_in only
    // reaches it while idle, so later changes cannot disturb a running scan.
    assign w_enc_in = (r_state == StIdle) ? bus.mask_in : w_pending_next;

    always_comb begin
        w_enc_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_enc_in[i]) begin
                w_enc_idx = 8'(i);
            end
        end
    end

    assign w_enc_nonzero = (w_enc_in != '0);
    assign w_enc_single  = w_enc_nonzero && ((w_enc_in & (w_enc_in - WIDTH'(1))) == '0);

    always_comb begin
        w_state_next  = r_state;
        w_pending_d   = r_pending;
        w_out_idx_d   = r_out_idx;
        w_out_valid_d = r_out_valid;
        w_out_last_d  = r_out_last;
        w_done_d      = 1'b0;
        w_busy_d      = r_busy;
        w_count_d     = r_count;

        unique case (r_state)
            StIdle: begin
                if (bus.go && !bus.abort) begin
                    w_pending_d = bus.mask_in;
                    w_count_d   = '0;
                    w_busy_d    = 1'b1;
                    if (w_enc_nonzero) begin
                        w_state_next  = StEmit;
                        w_out_valid_d = 1'b1;
                        w_out_idx_d   = w_enc_idx;
                        w_out_last_d  = w_enc_single;
                    end else begin
                        w_state_next = StFin;
                        w_done_d     = 1'b1;
                    end
                end
            end
            StEmit: begin
                if (bus.abort) begin
                    w_state_next  = StIdle;
                    w_pending_d   = '0;
                    w_out_valid_d = 1'b0;
                    w_out_last_d  = 1'b0;
                    w_busy_d      = 1'b0;
                end else if (bus.out_ready) begin
                    w_pending_d = w_pending_next;
                    w_count_d   = r_count + CW'(1);
                    if (w_enc_nonzero) begin
                        w_out_idx_d  = w_enc_idx;
                        w_out_last_d = w_enc_single;
                    end else begin
                        w_state_next  = StFin;
                        w_out_valid_d = 1'b0;
                        w_out_last_d  = 1'b0;
                        w_done_d      = 1'b1;
                    end
                end
            end
            StFin: begin
                w_state_next = StIdle;
                w_pending_d  = '0;
                w_busy_d     = 1'b0;
            end
            default: begin
                w_state_next  = StIdle;
                w_pending_d   = '0;
                w_out_valid_d = 1'b0;
                w_out_last_d  = 1'b0;
                w_busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_pending   <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pending   <= w_pending_d;
            r_out_idx   <= w_out_idx_d;
            r_out_valid <= w_out_valid_d;
            r_out_last  <= w_out_last_d;
            r_done      <= w_done_d;
            r_busy      <= w_busy_d;
            r_count     <= w_count_d;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_last  = r_out_last;
    assign bus.done      = r_done;
    assign bus.count     = r_count;
endmodule

// File: tb/tb_prio_scan_ctrl.sv
// Self-checking bench for prio_scan_ctrl: table of scans checked against a
// queue of expected indices, plus hand-written abort and reset sequences.
module tb_prio_scan_ctrl;
    localparam int unsigned WL = 4;
    localparam int unsigned W  = 1 << WL;

    typedef struct {
        logic [W-1:0] mask;
        int           mode;     // 0 always ready, 1 toggle, 2 stall 5, 3 random
        int           exp_cnt;
        bit           go_mid;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [7:0] exp_q[$];
    vec_t vecs[8];

    prio_scan_ctrl_if #(.WIDTH_LOG(WL)) ifc ();

    prio_scan_ctrl #(.WIDTH_LOG(WL)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic run_scan(input logic [W-1:0] mask, input int mode, input int exp_cnt,
                            input bit go_mid);
        int  cyc;
        bit  seen_done;
        bit  rdy;
        exp_q.delete();
        for (int i = W - 1; i >= 0; i--) begin
            if (mask[i]) exp_q.push_back(i[7:0]);
        end
        @(negedge clk);
        ifc.go        = 1'b1;
        ifc.mask_in   = mask;
        ifc.out_ready = 1'b0;
        @(negedge clk);
        ifc.go      = 1'b0;
        ifc.mask_in = ~mask;
        chk("lat_valid", int'(ifc.out_valid), int'(mask != '0));
        chk("lat_done", int'(ifc.done), int'(mask == '0));
        chk("lat_busy", int'(ifc.busy), 1);
        cyc       = 0;
        seen_done = 1'b0;
        while (!seen_done && cyc < 200) begin
            if (ifc.done) begin
                seen_done = 1'b1;
            end else begin
                if (ifc.out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_idx", int'(ifc.out_idx), -1);
                    end else begin
                        chk("out_idx", int'(ifc.out_idx), int'(exp_q[0]));
                        chk("out_last", int'(ifc.out_last), int'(exp_q.size() == 1));
                    end
                end
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = (cyc % 2 == 0);
                    2:       rdy = (cyc >= 5);
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                ifc.out_ready = rdy;
                ifc.go        = go_mid && (cyc == 3);
                ifc.mask_in   = 16'h0001;
                if (ifc.out_valid && rdy && exp_q.size() != 0) void'(exp_q.pop_front());
                @(negedge clk);
                cyc++;
            end
        end
        ifc.go = 1'b0;
        chk("done_seen", int'(seen_done), 1);
        chk("count", int'(ifc.count), exp_cnt);
        chk("queue_left", exp_q.size(), 0);
        chk("valid_at_done", int'(ifc.out_valid), 0);
        ifc.out_ready = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", int'(ifc.done), 0);
        chk("busy_after", int'(ifc.busy), 0);
        chk("count_hold", int'(ifc.count), exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        vecs[0] = '{mask: 16'h8421, mode: 0, exp_cnt: 4,  go_mid: 1'b0};
        vecs[1] = '{mask: 16'h0000, mode: 0, exp_cnt: 0,  go_mid: 1'b0};
        vecs[2] = '{mask: 16'h0006, mode: 2, exp_cnt: 2,  go_mid: 1'b0};
        vecs[3] = '{mask: 16'hFFFF, mode: 1, exp_cnt: 16, go_mid: 1'b1};
        vecs[4] = '{mask: 16'h0001, mode: 0, exp_cnt: 1,  go_mid: 1'b0};
        vecs[5] = '{mask: 16'h8000, mode: 1, exp_cnt: 1,  go_mid: 1'b0};
        vecs[6] = '{mask: 16'h5555, mode: 3, exp_cnt: 8,  go_mid: 1'b1};
        vecs[7] = '{mask: 16'hA0C3, mode: 0, exp_cnt: 6,  go_mid: 1'b0};

        rst_n         = 1'b0;
        ifc.go        = 1'b0;
        ifc.abort     = 1'b0;
        ifc.mask_in   = '0;
        ifc.out_ready = 1'b0;
        #17;
        chk("rst_busy", int'(ifc.busy), 0);
        chk("rst_valid", int'(ifc.out_valid), 0);
        chk("rst_idx", int'(ifc.out_idx), 0);
        chk("rst_done", int'(ifc.done), 0);
        chk("rst_count", int'(ifc.count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) run_scan(vecs[k].mask, vecs[k].mode, vecs[k].exp_cnt, vecs[k].go_mid);

        // abort in IDLE blocks a simultaneous go
        @(negedge clk);
        ifc.go      = 1'b1;
        ifc.abort   = 1'b1;
        ifc.mask_in = 16'h00FF;
        @(negedge clk);
        ifc.go    = 1'b0;
        ifc.abort = 1'b0;
        chk("idle_abort_busy", int'(ifc.busy), 0);
        chk("idle_abort_count", int'(ifc.count), 6);

        // abort together with the second handshake of F000
        ifc.go      = 1'b1;
        ifc.mask_in = 16'hF000;
        @(negedge clk);
        ifc.go = 1'b0;
        chk("ab_idx0", int'(ifc.out_idx), 15);
        ifc.out_ready = 1'b1;
        @(negedge clk);
        chk("ab_idx1", int'(ifc.out_idx), 14);
        ifc.abort = 1'b1;
        @(negedge clk);
        ifc.abort     = 1'b0;
        ifc.out_ready = 1'b0;
        chk("ab_valid", int'(ifc.out_valid), 0);
        chk("ab_busy", int'(ifc.busy), 0);
        chk("ab_done", int'(ifc.done), 0);
        chk("ab_last", int'(ifc.out_last), 0);
        chk("ab_count", int'(ifc.count), 1);
        @(negedge clk);
        chk("ab_no_done", int'(ifc.done), 0);
        run_scan(16'h0300, 0, 2, 1'b0);

        // asynchronous reset mid-EMIT
        @(negedge clk);
        ifc.go      = 1'b1;
        ifc.mask_in = 16'h00F0;
        @(negedge clk);
        ifc.go = 1'b0;
        chk("pre_rst_valid", int'(ifc.out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(ifc.busy), 0);
        chk("arst_valid", int'(ifc.out_valid), 0);
        chk("arst_idx", int'(ifc.out_idx), 0);
        chk("arst_last", int'(ifc.out_last), 0);
        chk("arst_done", int'(ifc.done), 0);
        chk("arst_count", int'(ifc.count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_scan(16'h0001, 0, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
